// File: rtl/fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_drain
// Purpose  : Read-side consumer for the common FIFO (read clock domain).
//            Pops words from the FIFO read port and presents them on a
//            valid/ready stream. A small circular output buffer hides the
//            FIFO read latency, so the stream sustains one word per cycle.
//            Pops are credit based and never underflow the FIFO or
//            overflow the buffer.
// Ports    : clk_r, rst_r_n          - read clock, async active-low reset
//            empty, rd_en, rd_data   - FIFO read port (rd_data RD_LAT late)
//            enable                  - gate for issuing new pops
//            flush                   - drop buffered and in-flight words
//            out_valid/out_data/out_ready - output stream
//            idle                    - nothing held, nothing in flight,
//                                      enable low (registered)
//            word_cnt, stall_cnt     - statistics (optional, see below)
// Options  : define FIFO_RD_DRAIN_STATS_EN to add the saturating word_cnt
//            and stall_cnt counters and their output ports.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_drain #(
  parameter int WIDTH     = 8,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = RD_LAT + 1
) (
  input  logic             clk_r,
  input  logic             rst_r_n,
  input  logic             empty,
  output logic             rd_en,
  input  logic [WIDTH-1:0] rd_data,
  input  logic             enable,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             idle
`ifdef FIFO_RD_DRAIN_STATS_EN
  ,
  output logic [31:0]      word_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int SR_W  = (RD_LAT > 0) ? RD_LAT : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

  logic [WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [WIDTH-1:0] buf_d [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic             idle_q, idle_d;
  logic             pop_out;
  logic             capture;
  logic             wr_fire;
  int               inflight;
  int               credits;

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid = (count_q != '0);
  assign out_data  = buf_q[rd_ptr_q];
  assign pop_out   = out_valid & out_ready;
  assign idle      = idle_q;

  // A slot is reserved for every word in flight, so a return can always
  // land. A same-cycle stream pop frees one slot, which keeps the stream
  // at full rate with the minimum buffer depth.
  always_comb begin
    inflight = $countones(sr_q);
    credits  = BUF_DEPTH - int'(count_q) - inflight;
    rd_en    = rst_r_n & enable & ~empty & ~flush & ((credits > 0) | pop_out);
  end

  generate
    if (RD_LAT == 0) begin : g_lat_zero
      // Data is on rd_data in the pop cycle itself; nothing is ever in flight.
      assign capture = rd_en;
      assign sr_d    = '0;
    end else begin : g_lat_pipe
      // The bit leaving the top of the shift register marks rd_data valid.
      assign capture = sr_q[SR_W-1];
      assign sr_d    = flush ? '0 : ((sr_q << 1) | SR_W'(rd_en));
    end
  endgenerate

  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Returns arriving during a flush are dropped.
    wr_fire  = capture & ~flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_fire) begin
        buf_d[wr_ptr_q] = rd_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_out) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({wr_fire, pop_out})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  assign idle_d = (count_q == '0) & (sr_q == '0) & ~enable;

  always_ff @(posedge clk_r or negedge rst_r_n) begin
    if (!rst_r_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sr_q     <= '0;
      idle_q   <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sr_q     <= sr_d;
      idle_q   <= idle_d;
    end
  end

`ifdef FIFO_RD_DRAIN_STATS_EN
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    word_cnt_d  = word_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      word_cnt_d  = '0;
      stall_cnt_d = '0;
    end else begin
      if (pop_out && (word_cnt_q != 32'hFFFF_FFFF)) begin
        word_cnt_d = word_cnt_q + 32'd1;
      end
      if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_r or negedge rst_r_n) begin
    if (!rst_r_n) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign word_cnt  = word_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-side consumer for the common FIFO; lives in the read clock domain.
- Pops words from the FIFO read port (empty/rd_en/rd_data) and presents them on a valid/ready stream.
- Hides the FIFO read latency with a small internal output buffer, so the stream runs at one word per cycle under continuous out_ready.
- Never underflows the FIFO and never drops a word.

Parameters:
- WIDTH, 8, data width; must match the FIFO WIDTH.
- RD_LAT, 1, FIFO read latency in cycles from rd_en to rd_data valid; legal values 0..2.
- BUF_DEPTH, RD_LAT+1, output buffer entries; minimum for full throughput; must be >= 1.

Ports:
- clk_r  in  1  read-side clock.
- rst_r_n  in  1  asynchronous active-low reset.
- empty  in  1  FIFO empty flag.
- rd_en  out  1  FIFO pop strobe.
- rd_data  in  WIDTH  FIFO read data, valid RD_LAT cycles after rd_en.
- enable  in  1  when low, no new pops are issued; in-flight reads still complete.
- flush  in  1  synchronous; discards buffered and in-flight data.
- out_valid  out  1  stream data valid.
- out_data  out  WIDTH  stream data, head of the output buffer.
- out_ready  in  1  stream consumer ready.
- idle  out  1  high when the buffer is empty, nothing is in flight and enable is low.

Behaviour:
- Reset: while rst_r_n is low, asynchronously clear rd_en=0, out_valid=0, out_data=0, idle=0, and clear the in-flight shift register, buffer pointers and count.
- Credits: credits = BUF_DEPTH - buf_count - inflight, where inflight is the popcount of the RD_LAT-bit shift register.
  - rd_en = enable & ~empty & ~flush & (credits>0 | pop_out).
  - pop_out = out_valid & out_ready. The same-cycle pop frees a slot, which gives full throughput.
  - rd_en is combinational from registered state plus empty/enable/flush/out_ready. It never asserts while empty=1.
- In-flight tracking: shift register sr[RD_LAT-1:0], with sr[0] <= rd_en. The bit leaving sr[RD_LAT-1] marks rd_data valid in that cycle. For RD_LAT=0, rd_data is captured in the same cycle rd_en is high.
- Buffer: circular, BUF_DEPTH entries, write pointer and read pointer of width max(1,$clog2(BUF_DEPTH)), with wrap at BUF_DEPTH-1 to 0 (non-power-of-2 allowed). buf_count has width $clog2(BUF_DEPTH+1).
  - Capture and pop in the same cycle: count unchanged, both pointers advance.
  - The capture into a full buffer cannot occur by construction. Verification asserts it.
- Output: out_valid = (buf_count != 0); out_data = buf[rd_ptr]. Both are registered-state driven with no combinational path from rd_data.
  - When out_valid=1 and out_ready=0, out_valid and out_data hold stable until accepted.
- enable deassert mid-burst: stop issuing pops that cycle. Words already in flight land in the buffer and drain normally.
- flush (1 cycle or longer):
  - Next edge: buffer pointers and count are cleared and sr is cleared.
  - Returns arriving in the flush cycle are discarded.
  - rd_en is forced 0 during flush.
  - out_valid is 0 from the cycle after flush.
  - FIFO words popped before flush are lost by design.
- idle is a registered version of (buf_count==0 & sr==0 & ~enable).
- Latency: with the buffer empty and RD_LAT=L, rd_en at cycle t gives out_valid at cycle t+L+1 (registered capture).

Optional Feature:
- FIFO_RD_DRAIN_STATS_EN defined:
  - Adds outputs word_cnt[31:0] (increments on each pop_out) and stall_cnt[31:0] (increments when out_valid & ~out_ready).
  - Both counters saturate at 32'hFFFF_FFFF.
  - Both are cleared by reset and by flush.
- Not defined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- RD_LAT=1: preload FIFO with 0x11..0x18, enable=1, out_ready=1 → rd_en high 8 consecutive cycles; out_data 0x11..0x18 on 8 consecutive cycles, first word 2 cycles after the first rd_en; rd_en never high with empty=1.
- out_ready=0 for 5 cycles mid-stream (RD_LAT=2, BUF_DEPTH=3) → at most 3 pops issued then rd_en=0; out_data held at the same value; resume → no loss, order preserved.
- FIFO goes empty after word 0x13, refilled 4 cycles later with 0x14 → out_valid gaps, then 0x14 delivered; no spurious rd_en while empty.
- flush asserted with 2 words buffered and 1 in flight → out_valid=0 the next cycle; the in-flight return is discarded; the next delivered word is the FIFO head at the next pop.
- rst_r_n pulsed low asynchronously mid-burst (not clock-aligned) → outputs 0 immediately; after release, the first pop waits for ~empty and enable.
- With FIFO_RD_DRAIN_STATS_EN: 10 transfers plus 4 stall cycles → word_cnt=10, stall_cnt=4; flush → both 0.
